// File: rtl/exmem_pkg.sv
// exmem_pkg: shared definitions for the EX/MEM pipeline stage.
//   - ALUop class encodings and the R-type opcodes decoded in EX
//   - multiplier FSM state type and state constants
//   - pipeline control bundle and the operand-forwarding helper
package exmem_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;  // address generation
    localparam logic [1:0] ALUOP_PASSB = 2'b01;  // CBZ: pass operand B
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;  // decode ALUcontrol_in
    localparam logic [1:0] ALUOP_ZERO  = 2'b11;  // result forced to 0

    localparam logic [10:0] OPC_ADD = 11'b10001011000;
    localparam logic [10:0] OPC_SUB = 11'b11001011000;
    localparam logic [10:0] OPC_AND = 11'b10001010000;
    localparam logic [10:0] OPC_ORR = 11'b10101010000;
    localparam logic [10:0] OPC_MUL = 11'b10011011000;

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE     = 1'b0;
    localparam state_t ST_MUL_BUSY = 1'b1;

    typedef struct packed {
        logic is_branch;
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic mem_to_reg;
    } ctrl_t;

    // EX/MEM result beats MEM/WB; X31 is the zero register and never forwards.
    function automatic logic [63:0] fwd_pick(
        input logic [4:0]  src_reg,
        input logic [63:0] reg_val,
        input logic        exm_rw,
        input logic [4:0]  exm_wr,
        input logic [63:0] exm_val,
        input logic        mwb_rw,
        input logic [4:0]  mwb_wr,
        input logic [63:0] mwb_val
    );
        logic [63:0] r;
        r = reg_val;
        if (src_reg != 5'd31) begin
            if (exm_rw && exm_wr == src_reg)
                r = exm_val;
            else if (mwb_rw && mwb_wr == src_reg)
                r = mwb_val;
        end
        return r;
    endfunction

endpackage

// File: rtl/exmem_stage_mul.sv
// mul64_iter: radix-2 shift-add multiplier, one partial product per cycle.
//   clk, rst_n   : clock, async active-low reset (aborts any multiply)
//   start        : load operands a/b and enter MUL_BUSY (ignored while busy)
//   abort        : drop any multiply in flight and return to IDLE
//   busy         : in MUL_BUSY
//   done         : final step this cycle (cnt==63); product is valid now
//   product      : low 64 bits of a*b, combinational, valid with done
module mul64_iter
    import exmem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic        busy,
    output logic        done,
    output logic [63:0] product
);

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [63:0] mcand_q, mcand_d;
    logic [63:0] mplier_q, mplier_d;
    logic [63:0] acc_step;

    // Partial sum including the bit processed this cycle; on the last step
    // this is the full product so the stage can latch it without waiting.
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : 64'd0);

    assign busy    = (state_q == ST_MUL_BUSY);
    assign done    = busy && (cnt_q == 6'd63);
    assign product = acc_step;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (abort) begin
            state_d  = ST_IDLE;
            cnt_d    = 6'd0;
            acc_d    = 64'd0;
            mcand_d  = 64'd0;
            mplier_d = 64'd0;
        end else if (state_q == ST_IDLE) begin
            if (start) begin
                state_d  = ST_MUL_BUSY;
                cnt_d    = 6'd0;
                acc_d    = 64'd0;
                mcand_d  = a;
                mplier_d = b;
            end
        end else begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            if (cnt_q == 6'd63) begin
                state_d = ST_IDLE;
                cnt_d   = 6'd0;
            end else begin
                cnt_d = cnt_q + 6'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 6'd0;
            acc_q    <= 64'd0;
            mcand_q  <= 64'd0;
            mplier_q <= 64'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

endmodule

// File: rtl/exmem_stage.sv
// exmem_stage: EX stage with forwarding, ALU, branch-target adder and the
// EX/MEM pipeline register. MUL runs on the iterative multiplier and stalls
// upstream until its final step.
//   CLOCK, RESET_N          : clock, async active-low reset
//   *_in                    : ID/EX register contents (control, data, regs)
//   memwb_*                 : MEM/WB write-back, used as a forwarding source
//   flush                   : squash the instruction in EX (also aborts MUL)
//   stall_out               : combinational, hold ID/EX and earlier
//   *_out                   : registered EX/MEM control, flag and data
module exmem_stage
    import exmem_pkg::*;
(
    input  logic        CLOCK,
    input  logic        RESET_N,
    input  logic [1:0]  ALUop_in,
    input  logic        ALUsrc_in,
    input  logic        isBranch_in,
    input  logic        memRead_in,
    input  logic        memWrite_in,
    input  logic        regWrite_in,
    input  logic        memToReg_in,
    input  logic [63:0] programCounter_in,
    input  logic [63:0] regData1_in,
    input  logic [63:0] regData2_in,
    input  logic [63:0] signExtend_in,
    input  logic [10:0] ALUcontrol_in,
    input  logic [4:0]  registerRn_in,
    input  logic [4:0]  registerRm_in,
    input  logic [4:0]  writeReg_in,
    input  logic        memwb_regWrite,
    input  logic [4:0]  memwb_writeReg,
    input  logic [63:0] memwb_data,
    input  logic        flush,
    output logic        stall_out,
    output logic        isBranch_out,
    output logic        memRead_out,
    output logic        memWrite_out,
    output logic        regWrite_out,
    output logic        memToReg_out,
    output logic        aluZero_out,
    output logic [63:0] branchTarget_out,
    output logic [63:0] aluResult_out,
    output logic [63:0] writeData_out,
    output logic [4:0]  writeReg_out
);

    ctrl_t       ctrl_in;
    ctrl_t       ctrl_q, ctrl_d;
    logic        zero_q, zero_d;
    logic [63:0] res_q, res_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] btgt_q, btgt_d;
    logic [4:0]  wreg_q, wreg_d;
    // Instruction context held while the multiplier iterates
    ctrl_t       cap_ctrl_q, cap_ctrl_d;
    logic [63:0] cap_wdata_q, cap_wdata_d;
    logic [4:0]  cap_wreg_q, cap_wreg_d;

    logic [63:0] fwd_a, fwd_b, op_b, alu_res;
    logic        is_mul, mul_start, mul_busy, mul_done;
    logic [63:0] mul_product;

    assign ctrl_in = {isBranch_in, memRead_in, memWrite_in, regWrite_in, memToReg_in};

    assign fwd_a = fwd_pick(registerRn_in, regData1_in, ctrl_q.reg_write, wreg_q, res_q,
                            memwb_regWrite, memwb_writeReg, memwb_data);
    assign fwd_b = fwd_pick(registerRm_in, regData2_in, ctrl_q.reg_write, wreg_q, res_q,
                            memwb_regWrite, memwb_writeReg, memwb_data);
    assign op_b  = ALUsrc_in ? signExtend_in : fwd_b;

    always_comb begin
        alu_res = 64'd0;
        case (ALUop_in)
            ALUOP_ADD:   alu_res = fwd_a + op_b;
            ALUOP_PASSB: alu_res = op_b;
            ALUOP_RTYPE: begin
                case (ALUcontrol_in)
                    OPC_ADD: alu_res = fwd_a + op_b;
                    OPC_SUB: alu_res = fwd_a - op_b;
                    OPC_AND: alu_res = fwd_a & op_b;
                    OPC_ORR: alu_res = fwd_a | op_b;
                    default: alu_res = 64'd0;  // MUL goes through mul64_iter
                endcase
            end
            ALUOP_ZERO:  alu_res = 64'd0;
            default:     alu_res = 64'd0;
        endcase
    end

    assign is_mul    = (ALUop_in == ALUOP_RTYPE) && (ALUcontrol_in == OPC_MUL);
    assign mul_start = is_mul && !mul_busy && !flush;

    mul64_iter u_mul (
        .clk     (CLOCK),
        .rst_n   (RESET_N),
        .start   (mul_start),
        .abort   (flush),
        .a       (fwd_a),
        .b       (fwd_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // The MUL stays in ID/EX while stalled, so it must not look like a new
    // request once the multiplier is busy; mul_start covers that.
    assign stall_out = RESET_N && !flush && (mul_start || (mul_busy && !mul_done));

    // Bubbles only clear control; data registers hold their old values.
    always_comb begin
        ctrl_d      = ctrl_q;
        res_d       = res_q;
        wdata_d     = wdata_q;
        btgt_d      = btgt_q;
        wreg_d      = wreg_q;
        cap_ctrl_d  = cap_ctrl_q;
        cap_wdata_d = cap_wdata_q;
        cap_wreg_d  = cap_wreg_q;
        if (flush) begin
            ctrl_d = '0;
        end else if (mul_done) begin
            ctrl_d  = cap_ctrl_q;
            res_d   = mul_product;
            wdata_d = cap_wdata_q;
            wreg_d  = cap_wreg_q;
        end else if (mul_busy) begin
            ctrl_d = '0;
        end else if (mul_start) begin
            ctrl_d      = '0;
            cap_ctrl_d  = ctrl_in;
            cap_wdata_d = fwd_b;
            cap_wreg_d  = writeReg_in;
        end else begin
            ctrl_d  = ctrl_in;
            res_d   = alu_res;
            wdata_d = fwd_b;
            wreg_d  = writeReg_in;
            btgt_d  = programCounter_in + (signExtend_in << 2);
        end
        zero_d = (res_d == 64'd0);
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            ctrl_q      <= '0;
            zero_q      <= 1'b0;
            res_q       <= 64'd0;
            wdata_q     <= 64'd0;
            btgt_q      <= 64'd0;
            wreg_q      <= 5'd0;
            cap_ctrl_q  <= '0;
            cap_wdata_q <= 64'd0;
            cap_wreg_q  <= 5'd0;
        end else begin
            ctrl_q      <= ctrl_d;
            zero_q      <= zero_d;
            res_q       <= res_d;
            wdata_q     <= wdata_d;
            btgt_q      <= btgt_d;
            wreg_q      <= wreg_d;
            cap_ctrl_q  <= cap_ctrl_d;
            cap_wdata_q <= cap_wdata_d;
            cap_wreg_q  <= cap_wreg_d;
        end
    end

    assign isBranch_out     = ctrl_q.is_branch;
    assign memRead_out      = ctrl_q.mem_read;
    assign memWrite_out     = ctrl_q.mem_write;
    assign regWrite_out     = ctrl_q.reg_write;
    assign memToReg_out     = ctrl_q.mem_to_reg;
    assign aluZero_out      = zero_q;
    assign aluResult_out    = res_q;
    assign writeData_out    = wdata_q;
    assign branchTarget_out = btgt_q;
    assign writeReg_out     = wreg_q;

endmodule

// File: tb/tb_exmem_stage.sv
// tb_exmem_stage: directed vector table for single-cycle ops and forwarding,
// plus hand-written sequences for MUL latency, flush and reset mid-MUL.
module tb_exmem_stage;
    import exmem_pkg::*;

    logic        CLOCK = 1'b0;
    logic        RESET_N;
    logic [1:0]  ALUop_in;
    logic        ALUsrc_in, isBranch_in, memRead_in, memWrite_in, regWrite_in, memToReg_in;
    logic [63:0] programCounter_in, regData1_in, regData2_in, signExtend_in;
    logic [10:0] ALUcontrol_in;
    logic [4:0]  registerRn_in, registerRm_in, writeReg_in;
    logic        memwb_regWrite;
    logic [4:0]  memwb_writeReg;
    logic [63:0] memwb_data;
    logic        flush;
    logic        stall_out;
    logic        isBranch_out, memRead_out, memWrite_out, regWrite_out, memToReg_out, aluZero_out;
    logic [63:0] branchTarget_out, aluResult_out, writeData_out;
    logic [4:0]  writeReg_out;

    exmem_stage dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N),
        .ALUop_in(ALUop_in), .ALUsrc_in(ALUsrc_in), .isBranch_in(isBranch_in),
        .memRead_in(memRead_in), .memWrite_in(memWrite_in), .regWrite_in(regWrite_in),
        .memToReg_in(memToReg_in), .programCounter_in(programCounter_in),
        .regData1_in(regData1_in), .regData2_in(regData2_in), .signExtend_in(signExtend_in),
        .ALUcontrol_in(ALUcontrol_in), .registerRn_in(registerRn_in),
        .registerRm_in(registerRm_in), .writeReg_in(writeReg_in),
        .memwb_regWrite(memwb_regWrite), .memwb_writeReg(memwb_writeReg),
        .memwb_data(memwb_data), .flush(flush), .stall_out(stall_out),
        .isBranch_out(isBranch_out), .memRead_out(memRead_out), .memWrite_out(memWrite_out),
        .regWrite_out(regWrite_out), .memToReg_out(memToReg_out), .aluZero_out(aluZero_out),
        .branchTarget_out(branchTarget_out), .aluResult_out(aluResult_out),
        .writeData_out(writeData_out), .writeReg_out(writeReg_out)
    );

    always #5 CLOCK = ~CLOCK;

    // control bundle order: {isBranch, memRead, memWrite, regWrite, memToReg}
    localparam logic [4:0] C_R  = 5'b00010;
    localparam logic [4:0] C_LD = 5'b01011;
    localparam logic [4:0] C_ST = 5'b00100;
    localparam logic [4:0] C_CB = 5'b10000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct {
        logic [1:0]  op;
        logic [10:0] ctl;
        logic        src;
        logic [4:0]  ctrl;
        logic [63:0] pc, r1, r2, se;
        logic [4:0]  rn, rm, wr;
        logic        mw_rw;
        logic [4:0]  mw_wr;
        logic [63:0] mw_d;
        logic [63:0] e_res, e_wd, e_bt;
        logic        e_zero;
    } vec_t;

    vec_t vt [0:16];
    vec_t v;
    int   n_checks = 0;
    int   n_err    = 0;
    int   stall_cnt, bubble_bad;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t d);
        RESET_N           = 1'b1;
        flush             = 1'b0;
        ALUop_in          = d.op;
        ALUcontrol_in     = d.ctl;
        ALUsrc_in         = d.src;
        {isBranch_in, memRead_in, memWrite_in, regWrite_in, memToReg_in} = d.ctrl;
        programCounter_in = d.pc;
        regData1_in       = d.r1;
        regData2_in       = d.r2;
        signExtend_in     = d.se;
        registerRn_in     = d.rn;
        registerRm_in     = d.rm;
        writeReg_in       = d.wr;
        memwb_regWrite    = d.mw_rw;
        memwb_writeReg    = d.mw_wr;
        memwb_data        = d.mw_d;
    endtask

    function automatic logic [63:0] ctrl_now();
        return 64'({isBranch_out, memRead_out, memWrite_out, regWrite_out, memToReg_out});
    endfunction

    task automatic run_vec(input string nm, input vec_t d);
        @(negedge CLOCK);
        drive(d);
        #1 chk({nm, ".stall"}, 64'(stall_out), 64'd0);
        @(posedge CLOCK);
        #1;
        chk({nm, ".res"},  aluResult_out, d.e_res);
        chk({nm, ".zero"}, 64'(aluZero_out), 64'(d.e_zero));
        chk({nm, ".bt"},   branchTarget_out, d.e_bt);
        chk({nm, ".ctrl"}, ctrl_now(), 64'(d.ctrl));
        chk({nm, ".wreg"}, 64'(writeReg_out), 64'(d.wr));
        chk({nm, ".wdata"}, writeData_out, d.e_wd);
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, ".stall"}, 64'(stall_out), 64'd0);
        chk({nm, ".ctrl"},  ctrl_now(), 64'd0);
        chk({nm, ".zero"},  64'(aluZero_out), 64'd0);
        chk({nm, ".res"},   aluResult_out, 64'd0);
        chk({nm, ".bt"},    branchTarget_out, 64'd0);
        chk({nm, ".wdata"}, writeData_out, 64'd0);
        chk({nm, ".wreg"},  64'(writeReg_out), 64'd0);
    endtask

    initial begin
        //          op     ctl      src   ctrl  pc        r1           r2           se          rn     rm     wr     mw_rw mw_wr  mw_d         res            wd           bt         z
        vt[0]  = '{2'b10, OPC_ADD, 1'b0, C_R,  64'h40,   64'd5,       64'd7,       64'd1,      5'd1,  5'd2,  5'd9,  1'b0, 5'd0,  64'd0,    64'd12,        64'd7,       64'h44,    1'b0};
        vt[1]  = '{2'b10, OPC_SUB, 1'b0, C_R,  64'h44,   64'd20,      64'd11,      64'd0,      5'd4,  5'd5,  5'd3,  1'b0, 5'd0,  64'd0,    64'd9,         64'd11,      64'h44,    1'b0};
        vt[2]  = '{2'b10, OPC_ADD, 1'b0, C_R,  64'h48,   64'd100,     64'd100,     64'd0,      5'd3,  5'd3,  5'd6,  1'b0, 5'd0,  64'd0,    64'd18,        64'd9,       64'h48,    1'b0};
        vt[3]  = '{2'b10, OPC_ORR, 1'b0, C_R,  64'h4c,   64'hF0,      64'h0F,      64'd0,      5'd10, 5'd11, 5'd7,  1'b0, 5'd0,  64'd0,    64'hFF,        64'h0F,      64'h4c,    1'b0};
        vt[4]  = '{2'b10, OPC_ADD, 1'b0, C_R,  64'h50,   64'd100,     64'd100,     64'd0,      5'd3,  5'd3,  5'd8,  1'b1, 5'd3,  64'd4,    64'd8,         64'd4,       64'h50,    1'b0};
        vt[5]  = '{2'b10, OPC_ADD, 1'b0, C_R,  64'h54,   64'd100,     64'd100,     64'd0,      5'd8,  5'd8,  5'd12, 1'b1, 5'd8,  64'd1000, 64'd16,        64'd8,       64'h54,    1'b0};
        vt[6]  = '{2'b10, OPC_ADD, 1'b0, C_R,  64'h58,   64'd2,       64'd3,       64'd0,      5'd31, 5'd31, 5'd31, 1'b1, 5'd31, 64'd77,   64'd5,         64'd3,       64'h58,    1'b0};
        vt[7]  = '{2'b10, OPC_ADD, 1'b0, C_R,  64'h5c,   64'd1,       64'd1,       64'd0,      5'd31, 5'd31, 5'd13, 1'b0, 5'd0,  64'd0,    64'd2,         64'd1,       64'h5c,    1'b0};
        vt[8]  = '{2'b10, OPC_AND, 1'b0, C_R,  64'h60,   64'hFF00,    64'h0FF0,    64'd0,      5'd20, 5'd21, 5'd14, 1'b0, 5'd0,  64'd0,    64'h0F00,      64'h0FF0,    64'h60,    1'b0};
        vt[9]  = '{2'b10, OPC_SUB, 1'b0, C_R,  64'h64,   64'h1234,    64'h1234,    64'd0,      5'd22, 5'd23, 5'd14, 1'b0, 5'd0,  64'd0,    64'd0,         64'h1234,    64'h64,    1'b1};
        vt[10] = '{2'b00, 11'd0,   1'b1, C_LD, 64'h68,   64'h1000,    64'h99,      64'h20,     5'd24, 5'd25, 5'd15, 1'b0, 5'd0,  64'd0,    64'h1020,      64'h99,      64'hE8,    1'b0};
        vt[11] = '{2'b01, 11'd0,   1'b0, C_CB, 64'h100,  64'd7,       64'h55,      64'd4,      5'd26, 5'd14, 5'd0,  1'b1, 5'd14, 64'd0,    64'd0,         64'd0,       64'h110,   1'b1};
        vt[12] = '{2'b11, OPC_ADD, 1'b0, C_ST, 64'h110,  64'h33,      64'h44,      64'd2,      5'd1,  5'd2,  5'd16, 1'b0, 5'd0,  64'd0,    64'd0,         64'h44,      64'h118,   1'b1};
        vt[13] = '{2'b10, 11'd0,   1'b0, C_R,  64'h114,  64'h33,      64'h44,      64'd0,      5'd1,  5'd2,  5'd17, 1'b0, 5'd0,  64'd0,    64'd0,         64'h44,      64'h114,   1'b1};
        vt[14] = '{2'b00, OPC_ADD, 1'b1, C_ST, 64'h118,  64'h2000,    64'hABCD,    64'd8,      5'd27, 5'd28, 5'd18, 1'b0, 5'd0,  64'd0,    64'h2008,      64'hABCD,    64'h138,   1'b0};
        vt[15] = '{2'b10, OPC_ADD, 1'b0, C_R,  64'hFFFF_FFFF_FFFF_FFF0, ONES, 64'd2, 64'd4, 5'd29, 5'd30, 5'd19, 1'b0, 5'd0,  64'd0,    64'd1,         64'd2,       64'd0,     1'b0};
        vt[16] = '{2'b01, 11'd0,   1'b0, C_CB, 64'h200,  64'd0,       64'd5,       64'hFFFF_FFFF_FFFF_FFFE, 5'd1, 5'd5, 5'd0, 1'b0, 5'd0, 64'd0, 64'd5,      64'd5,       64'h1F8,   1'b0};

        // reset with a MUL presented: outputs zero, stall held low
        v = vt[0];
        v.ctl = OPC_MUL;
        drive(v);
        RESET_N = 1'b1;
        #1 RESET_N = 1'b0;
        #11 check_all_zero("reset");

        for (int i = 0; i <= 16; i++)
            run_vec($sformatf("vec%0d", i), vt[i]);

        // MUL all-ones * 3: 64 stall cycles of bubbles, product on edge 65
        @(negedge CLOCK);
        v = '{2'b10, OPC_MUL, 1'b0, C_R, 64'h300, ONES, 64'd3, 64'd0, 5'd1, 5'd2, 5'd20,
              1'b0, 5'd0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0};
        drive(v);
        #1;
        stall_cnt  = 0;
        bubble_bad = 0;
        while (stall_out && stall_cnt < 100) begin
            stall_cnt++;
            @(posedge CLOCK);
            #1 if (ctrl_now() != 64'd0) bubble_bad++;
            @(negedge CLOCK);
            #1;
        end
        chk("mul.stall_cycles", 64'(stall_cnt), 64'd64);
        chk("mul.bubbles", 64'(bubble_bad), 64'd0);
        @(posedge CLOCK);
        #1;
        chk("mul.res",   aluResult_out, 64'hFFFF_FFFF_FFFF_FFFD);
        chk("mul.zero",  64'(aluZero_out), 64'd0);
        chk("mul.ctrl",  ctrl_now(), 64'(C_R));
        chk("mul.wreg",  64'(writeReg_out), 64'd20);
        chk("mul.wdata", writeData_out, 64'd3);

        // dependent ADD picks up the product through EX/MEM forwarding
        v = '{2'b10, OPC_ADD, 1'b0, C_R, 64'h304, 64'd0, 64'd1, 64'd0, 5'd20, 5'd31, 5'd21,
              1'b0, 5'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 64'h304, 1'b0};
        run_vec("mul_dep", v);

        // flush of a single-cycle op
        @(negedge CLOCK);
        drive(v);
        flush = 1'b1;
        #1 chk("flush_idle.stall", 64'(stall_out), 64'd0);
        @(posedge CLOCK);
        #1 chk("flush_idle.ctrl", ctrl_now(), 64'd0);

        // flush at MUL_BUSY cnt=20
        @(negedge CLOCK);
        v = '{2'b10, OPC_MUL, 1'b0, C_R, 64'h400, 64'd5, 64'd6, 64'd0, 5'd1, 5'd2, 5'd22,
              1'b0, 5'd0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0};
        drive(v);
        #1 chk("mflush.start_stall", 64'(stall_out), 64'd1);
        @(posedge CLOCK);               // enters MUL_BUSY, cnt=0
        repeat (20) @(posedge CLOCK);   // cnt=20
        @(negedge CLOCK);
        #1 chk("mflush.busy_stall", 64'(stall_out), 64'd1);
        flush = 1'b1;
        #1 chk("mflush.stall", 64'(stall_out), 64'd0);
        @(posedge CLOCK);
        #1 chk("mflush.ctrl", ctrl_now(), 64'd0);
        v = '{2'b10, OPC_ADD, 1'b0, C_R, 64'h404, 64'd10, 64'd20, 64'd0, 5'd1, 5'd2, 5'd25,
              1'b0, 5'd0, 64'd0, 64'd30, 64'd20, 64'h404, 1'b0};
        run_vec("after_flush", v);

        // reset asserted mid-MUL, then a normal ADD
        @(negedge CLOCK);
        v = '{2'b10, OPC_MUL, 1'b0, C_R, 64'h500, 64'd7, 64'd9, 64'd0, 5'd1, 5'd2, 5'd23,
              1'b0, 5'd0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0};
        drive(v);
        repeat (10) @(posedge CLOCK);
        #2 RESET_N = 1'b0;
        #1 check_all_zero("rst_mid_mul");
        v = '{2'b10, OPC_ADD, 1'b0, C_R, 64'h600, 64'd40, 64'd2, 64'd1, 5'd1, 5'd2, 5'd24,
              1'b0, 5'd0, 64'd0, 64'd42, 64'd2, 64'h604, 1'b0};
        run_vec("after_rst", v);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
